// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - constants and state encoding shared by the serial frame link
package serial_link_pkg;

    localparam int FRAME_DATA_WIDTH = 40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        GUARD = 2'd2
    } rx_state_t;

    localparam logic START_BIT  = 1'b1;
    localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// rtl/serial_frame_receiver_if.sv - valid/ready word port of the serial frame receiver
interface serial_frame_receiver_if
    import serial_link_pkg::*;
#(
    parameter int DATA_WIDTH = FRAME_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/serial_frame_receiver.sv
// rtl/serial_frame_receiver.sv - single-wire frame deserialiser with one-entry output holding register (guard check: SERIAL_RX_GUARD_CHECK_EN)
module serial_frame_receiver
    import serial_link_pkg::*;
#(
    parameter int DATA_WIDTH = FRAME_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sin,
    serial_frame_receiver_if.master  out_if,
    output logic                     overrun,
    output logic                     frame_error,
    output logic                     busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_DATA  = DATA;
`ifdef SERIAL_RX_GUARD_CHECK_EN
    localparam logic [1:0] ST_GUARD = GUARD;
`endif

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  overrun_q, overrun_d;
    logic                  busy_q, busy_d;
    logic                  deliver;
    logic [DATA_WIDTH-1:0] word;
`ifdef SERIAL_RX_GUARD_CHECK_EN
    logic                  frame_error_q, frame_error_d;
`endif

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shift_d     = shift_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;
        deliver     = 1'b0;
        word        = shift_q;
`ifdef SERIAL_RX_GUARD_CHECK_EN
        frame_error_d = 1'b0;
`endif

        if (out_valid_q && out_if.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (sin == START_BIT) begin
                    state_d = ST_DATA;
                    count_d = '0;
                end
            end
            ST_DATA: begin
                shift_d = {shift_q[DATA_WIDTH-2:0], sin};
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_BIT) begin
`ifdef SERIAL_RX_GUARD_CHECK_EN
                    state_d = ST_GUARD;
`else
                    // Deliver straight from the shifter so back-to-back frames keep up.
                    state_d = ST_IDLE;
                    deliver = 1'b1;
                    word    = shift_d;
`endif
                end
            end
`ifdef SERIAL_RX_GUARD_CHECK_EN
            ST_GUARD: begin
                // A high guard bit is an error, never a new start bit.
                state_d = ST_IDLE;
                if (sin == IDLE_LEVEL) begin
                    deliver = 1'b1;
                end else begin
                    frame_error_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (deliver) begin
            if (!out_valid_q || out_if.out_ready) begin
                out_data_d  = word;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

`ifdef SERIAL_RX_GUARD_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_error_q <= 1'b0;
        end else begin
            frame_error_q <= frame_error_d;
        end
    end

    assign frame_error = frame_error_q;
`else
    assign frame_error = 1'b0;
`endif

    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;
    assign overrun          = overrun_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb/tb_serial_frame_receiver.sv - scoreboard bench for serial_frame_receiver
module tb_serial_frame_receiver;
    import serial_link_pkg::*;

    localparam int W = FRAME_DATA_WIDTH;
`ifdef SERIAL_RX_GUARD_CHECK_EN
    localparam int LAT       = 41;
    localparam int FE_EXP    = 1;
    localparam int WORDS_EXP = 7;
`else
    localparam int LAT       = 40;
    localparam int FE_EXP    = 0;
    localparam int WORDS_EXP = 6;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sin   = 1'b0;
    logic overrun;
    logic frame_error;
    logic busy;

    serial_frame_receiver_if #(.DATA_WIDTH(W)) out_if ();

    serial_frame_receiver #(.DATA_WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sin         (sin),
        .out_if      (out_if),
        .overrun     (overrun),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int words_seen    = 0;
    int ovr_cnt       = 0;
    int fe_cnt        = 0;
    int last_word_cyc = -1;
    logic v_prev = 1'b0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: a word is newly presented when valid is set and the previous one was absent or consumed.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (overrun) ovr_cnt++;
            if (frame_error) fe_cnt++;
            if (out_if.out_valid && (!v_prev || out_if.out_ready)) begin
                words_seen++;
                last_word_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_word: got %0h expected none", out_if.out_data);
                end else begin
                    chk("word", 64'(out_if.out_data), 64'(exp_q.pop_front()));
                end
            end
            v_prev = out_if.out_valid;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sin = 1'b0;
        end
    endtask

    // Returns at the falling edge right after the delivery edge in both builds.
    task automatic send_frame(input logic [W-1:0] w, input logic guard, input logic raise_ready,
                              output int start_edge);
        @(negedge clk);
        sin = 1'b1;
        start_edge = cyc + 1;
        for (int i = W - 1; i >= 0; i--) begin
            @(negedge clk);
            sin = w[i];
`ifndef SERIAL_RX_GUARD_CHECK_EN
            if (i == 0 && raise_ready) out_if.out_ready = 1'b1;
`endif
        end
`ifdef SERIAL_RX_GUARD_CHECK_EN
        @(negedge clk);
        sin = guard;
        if (raise_ready) out_if.out_ready = 1'b1;
        @(negedge clk);
        sin = 1'b0;
`else
        @(negedge clk);
        sin = guard;
`endif
    endtask

    initial begin
        int se;
        int ovr0;
        int bad;
        logic [W-1:0] partial;
`ifdef SERIAL_RX_GUARD_CHECK_EN
        int fe0;
`endif
        partial = 40'hF0F0F0F0F0;
        out_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", 64'(out_if.out_valid), 0);
        chk("reset_data", 64'(out_if.out_data), 0);
        chk("reset_busy", 64'(busy), 0);
        chk("reset_overrun", 64'(overrun), 0);
        chk("reset_frame_error", 64'(frame_error), 0);
        rst_n = 1'b1;

        // Single frame, consumer always ready
        out_if.out_ready = 1'b1;
        exp_q.push_back(40'hD999999991);
        send_frame(40'hD999999991, 1'b0, 1'b0, se);
        chk("t1_valid", 64'(out_if.out_valid), 1);
        chk("t1_data", 64'(out_if.out_data), 64'h00D999999991);
        chk("t1_latency", 64'(last_word_cyc), 64'(se + LAT));
        @(negedge clk);
        chk("t1_valid_pulse", 64'(out_if.out_valid), 0);
        chk("t1_busy", 64'(busy), 0);

        // Second frame while first is held -> overrun
        out_if.out_ready = 1'b0;
        ovr0 = ovr_cnt;
        exp_q.push_back(40'hD999999991);
        send_frame(40'hD999999991, 1'b0, 1'b0, se);
        idle(2);
        send_frame(40'hD999999993, 1'b0, 1'b0, se);
        idle(3);
        chk("t2_overrun_once", 64'(ovr_cnt), 64'(ovr0 + 1));
        chk("t2_valid_held", 64'(out_if.out_valid), 1);
        chk("t2_data_held", 64'(out_if.out_data), 64'h00D999999991);
        out_if.out_ready = 1'b1;
        @(negedge clk);
        chk("t2_consumed", 64'(out_if.out_valid), 0);
        chk("t2_data_after_consume", 64'(out_if.out_data), 64'h00D999999991);

        // Delivery on the same edge that consumes the held word
        out_if.out_ready = 1'b0;
        idle(2);
        exp_q.push_back(40'hD999999995);
        send_frame(40'hD999999995, 1'b0, 1'b0, se);
        idle(3);
        chk("t3_first_held", 64'(out_if.out_valid), 1);
        exp_q.push_back(40'hD999999997);
        send_frame(40'hD999999997, 1'b0, 1'b1, se);
        chk("t3_valid_stays", 64'(out_if.out_valid), 1);
        chk("t3_data_new", 64'(out_if.out_data), 64'h00D999999997);
        chk("t3_no_overrun", 64'(ovr_cnt), 64'(ovr0 + 1));
        @(negedge clk);
        chk("t3_consumed", 64'(out_if.out_valid), 0);

`ifdef SERIAL_RX_GUARD_CHECK_EN
        // Guard bit high -> frame_error, word dropped, 1 not a start bit
        fe0 = fe_cnt;
        idle(2);
        send_frame(40'hFFFF0000FF, 1'b1, 1'b0, se);
        chk("t4_frame_error_pulse", 64'(frame_error), 1);
        chk("t4_fe_count", 64'(fe_cnt), 64'(fe0 + 1));
        chk("t4_busy_idle", 64'(busy), 0);
        chk("t4_valid_low", 64'(out_if.out_valid), 0);
        idle(2);
        exp_q.push_back(40'h0000000001);
        send_frame(40'h0000000001, 1'b0, 1'b0, se);
        chk("t4_next_valid", 64'(out_if.out_valid), 1);
        chk("t4_next_data", 64'(out_if.out_data), 64'h1);
        @(negedge clk);
`endif

        // Async reset mid-frame
        out_if.out_ready = 1'b0;
        idle(2);
        exp_q.push_back(40'h123456789A);
        send_frame(40'h123456789A, 1'b0, 1'b0, se);
        idle(2);
        chk("t5_held_before", 64'(out_if.out_valid), 1);
        @(negedge clk);
        sin = 1'b1;
        for (int i = W - 1; i >= W - 20; i--) begin
            @(negedge clk);
            sin = partial[i];
        end
        chk("t5_busy_before", 64'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(out_if.out_valid), 0);
        chk("t5_rst_data", 64'(out_if.out_data), 0);
        chk("t5_rst_busy", 64'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sin   = 1'b0;
        idle(20);
        chk("t5_trailing_busy", 64'(busy), 0);
        chk("t5_trailing_valid", 64'(out_if.out_valid), 0);
        out_if.out_ready = 1'b1;
        exp_q.push_back(40'hA5A5A5A5A5);
        send_frame(40'hA5A5A5A5A5, 1'b0, 1'b0, se);
        chk("t5_clean_valid", 64'(out_if.out_valid), 1);
        chk("t5_clean_data", 64'(out_if.out_data), 64'h00A5A5A5A5A5);

        // Long idle line stays quiet
        bad = 0;
        @(negedge clk);
        repeat (200) begin
            @(negedge clk);
            sin = 1'b0;
            if (busy || out_if.out_valid || overrun || frame_error) bad++;
        end
        chk("t6_idle_quiet", 64'(bad), 0);

        chk("end_queue_empty", 64'(exp_q.size()), 0);
        chk("end_words_seen", 64'(words_seen), 64'(WORDS_EXP));
        chk("end_overrun_total", 64'(ovr_cnt), 1);
        chk("end_frame_error_total", 64'(fe_cnt), 64'(FE_EXP));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Receive side of the single-wire serial frame link. Idle line is 0; each frame is one start bit (1) followed by DATA_WIDTH data bits, MSB first, one bit per clk, then a guard low. The block deserialises frames from `sin` and presents each word on a valid/ready output port with a one-entry holding register. It also flags overrun and (optionally) framing errors. It sits opposite the frame transmitter on the same clock.

## Interface
- DATA_WIDTH, 40, payload bits per frame
- clk  input  1  sole clock, all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- sin  input  1  serial line, synchronous to clk, idle 0
- out_data  output  DATA_WIDTH  received word, stable while out_valid=1
- out_valid  output  1  holding register full
- out_ready  input  1  consumer accepts word when out_valid & out_ready at posedge
- overrun  output  1  one-cycle pulse: completed frame dropped, holding register full
- frame_error  output  1  one-cycle pulse: guard bit was 1 (only with guard check compiled in, else tied 0)
- busy  output  1  high while not in IDLE

## Operation
- Reset (async, any time, including mid-frame):
  - state IDLE, count 0, shift register 0
  - out_data 0, out_valid 0, overrun 0, frame_error 0, busy 0
  - A partial frame is discarded.
- FSM states: IDLE, DATA, GUARD (GUARD exists only with the macro).
- IDLE:
  - sin=1 is a start bit: go to DATA, count←0.
  - sin=0: stay.
- DATA:
  - Each cycle shift sin into the LSB of the shift register; count←count+1.
  - When the DATA_WIDTH-th bit is sampled (count==DATA_WIDTH-1), the frame completes: go to GUARD with the macro, else deliver and go to IDLE.
- GUARD:
  - sin=0: deliver, go to IDLE.
  - sin=1: frame_error pulse, word discarded, go to IDLE. This 1 is not taken as a start bit.
- Deliver at edge E:
  - If out_valid=0, or out_ready=1 at E: out_data←shift register, out_valid←1.
  - Otherwise: overrun pulse, new word dropped, held word unchanged.
- Handshake:
  - out_valid & out_ready with no delivery at the same edge: out_valid←0.
  - out_data holds its value after consumption until the next delivery.
  - out_valid stays high until consumed. No timeout.
- Counter width: $clog2(DATA_WIDTH+1). It never wraps; it is reset on each start bit.

## Timing
- Start bit sampled at edge E0; data bits at E1..E_DATA_WIDTH (MSB first).
- Macro defined:
  - Guard bit sampled at E_DATA_WIDTH+1.
  - out_valid/frame_error/overrun become visible after that edge.
  - Earliest next start bit is sampled at E_DATA_WIDTH+2.
- Macro undefined:
  - out_valid visible after E_DATA_WIDTH.
  - Earliest next start bit is sampled at E_DATA_WIDTH+1, so back-to-back frames are accepted.
- The transmitter emits ≥2 idle zeros between frames, so both builds keep up at line rate.
- overrun and frame_error are high for exactly one cycle per event. busy equals (state != IDLE), registered.

## Configuration
- SERIAL_RX_GUARD_CHECK_EN
  - Defined: GUARD state present; a frame is accepted only if the bit after the last data bit is 0, else frame_error pulses and the frame is dropped.
  - Undefined: no GUARD state, frame_error tied 0, delivery one cycle earlier, any bit after the payload is treated as line state (a 1 starts a new frame).

## Structure
- Shared package serial_link_pkg:
  - FRAME_DATA_WIDTH = 40
  - rx_state_t enum {IDLE, DATA, GUARD}
  - START_BIT = 1'b1, IDLE_LEVEL = 1'b0
- The transmitter uses the same constants.
- No sub-module: the shift register, counter, FSM and holding register form one block.

## Test plan
- Single frame 40'hD999999991, zero guard, out_ready=1:
  - out_valid pulses one cycle with out_data=40'hD999999991, 41 cycles after the start-bit edge with the macro (40 cycles without).
- Two frames 40'hD999999991 then 40'hD999999993 with a 2-zero gap, out_ready=0:
  - First word held, overrun pulses once, out_data stays 40'hD999999991.
  - Then out_ready=1 clears out_valid.
- Delivery on the same edge that out_ready consumes the prior word:
  - New word 40'hD999999997 latched, out_valid stays 1, no overrun.
- Guard bit forced to 1 (macro defined):
  - frame_error pulses once, out_valid stays 0, FSM in IDLE the next cycle.
  - A following frame 40'h0000000001 is received correctly.
- rst_n asserted for one cycle after 20 data bits:
  - All outputs 0 immediately (async), trailing bits ignored until the next 1 in IDLE.
  - A subsequent clean frame decodes correctly.
- Idle line held 0 for 200 cycles:
  - busy, out_valid, overrun and frame_error stay 0.
